// File: rtl/matvec_stream_feeder.sv
// matvec_stream_feeder
// Host-side feeder for the KxK matrix-vector multiplier. A host loads a
// weight matrix W and a vector X through a simple write port. On start the
// feeder streams W (optionally) and then X to the multiplier over a
// valid/ready channel. It then consumes the K-word result stream into a
// result buffer that the host can read back combinationally.
module matvec_stream_feeder #(
    parameter int K  = 8,
    parameter int IW = 14,
    parameter int OW = 28
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cfg_we,
    input  logic                     cfg_sel,
    input  logic [$clog2(K*K)-1:0]   cfg_addr,
    input  logic signed [IW-1:0]     cfg_data,
    input  logic                     start,
    input  logic                     start_new_matrix,
    input  logic                     hold_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic signed [IW-1:0]     m_data,
    output logic                     m_new_matrix,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [OW-1:0]     s_data,
    input  logic [$clog2(K)-1:0]     res_addr,
    output logic signed [OW-1:0]     res_data
);

    localparam int AW = $clog2(K*K);
    localparam int XW = $clog2(K);

    localparam logic [AW-1:0] W_LAST = AW'(K*K-1);
    localparam logic [AW-1:0] X_LAST = AW'(K-1);
    localparam logic [XW-1:0] R_LAST = XW'(K-1);

    typedef enum logic [2:0] {
        IDLE,
        SEND_W,
        SEND_X,
        RECV,
        FIN
    } state_t;

    state_t state;

    // Shared word index for both W (row-major) and X transmission.
    logic [AW-1:0] idx;
    // Number of result words captured so far in RECV.
    logic [XW-1:0] rcnt;

    logic signed [IW-1:0] w_buf   [K*K];
    logic signed [IW-1:0] x_buf   [K];
    logic signed [OW-1:0] res_buf [K];

    logic m_fire;
    logic s_fire;
    logic cfg_ok;

    assign m_fire = m_valid && m_ready;
    assign s_fire = s_valid && s_ready;
    // Host writes are only honoured while no transaction is running, so the
    // words being streamed can never change underneath the multiplier.
    assign cfg_ok = cfg_we && (state == IDLE) && !reset;

    // Host load port for the W and X buffers; these are deliberately not reset.
    always_ff @(posedge clk) begin
        if (cfg_ok) begin
            if (!cfg_sel) begin
                w_buf[cfg_addr] <= cfg_data;
            end else begin
                x_buf[cfg_addr[XW-1:0]] <= cfg_data;
            end
        end
    end

    // Transaction sequencer: sends W/X words, counts results, pulses done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            idx          <= '0;
            rcnt         <= '0;
            m_valid      <= 1'b0;
            m_new_matrix <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        idx          <= '0;
                        rcnt         <= '0;
                        m_valid      <= 1'b1;
                        m_new_matrix <= start_new_matrix;
                        state        <= start_new_matrix ? SEND_W : SEND_X;
                    end
                end
                SEND_W: begin
                    if (m_fire) begin
                        m_new_matrix <= 1'b0;
                        if (idx == W_LAST) begin
                            idx   <= '0;
                            state <= SEND_X;
                        end else begin
                            idx <= idx + AW'(1);
                        end
                    end
                end
                SEND_X: begin
                    if (m_fire) begin
                        if (idx == X_LAST) begin
                            idx     <= '0;
                            m_valid <= 1'b0;
                            state   <= RECV;
                        end else begin
                            idx <= idx + AW'(1);
                        end
                    end
                end
                RECV: begin
                    if (s_fire) begin
                        rcnt <= rcnt + XW'(1);
                        if (rcnt == R_LAST) begin
                            done  <= 1'b1;
                            state <= FIN;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Result capture; the buffer is cleared by reset and otherwise holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < K; i++) begin
                res_buf[i] <= '0;
            end
        end else if (s_fire) begin
            res_buf[rcnt] <= s_data;
        end
    end

    // Outgoing word is read straight from the buffers by the current index.
    // Buffers are frozen while busy, so the word is stable during a stall.
    always_comb begin
        m_data = w_buf[idx];
        if (state == SEND_X) begin
            m_data = x_buf[idx[XW-1:0]];
        end
    end

    // s_ready follows hold_ready in the same cycle so backpressure is immediate.
    always_comb begin
        busy     = (state != IDLE);
        s_ready  = (state == RECV) && !hold_ready;
        res_data = res_buf[res_addr];
    end

endmodule

// File: tb/tb_matvec_stream_feeder.sv
// tb_matvec_stream_feeder
// Directed bench for matvec_stream_feeder with a small multiplier model.
module tb_matvec_stream_feeder;

    logic               clk = 1'b0;
    logic               reset;
    logic               cfg_we;
    logic               cfg_sel;
    logic [5:0]         cfg_addr;
    logic signed [13:0] cfg_data;
    logic               start;
    logic               start_new_matrix;
    logic               hold_ready;
    logic               busy;
    logic               done;
    logic               m_valid;
    logic               m_ready;
    logic signed [13:0] m_data;
    logic               m_new_matrix;
    logic               s_valid;
    logic               s_ready;
    logic signed [27:0] s_data;
    logic [2:0]         res_addr;
    logic signed [27:0] res_data;

    int n_cmp  = 0;
    int n_fail = 0;

    int tb_w [64];
    int tb_x [8];
    int exp_res [8];
    int res_vals [8];

    int got_data [80];
    int got_nm   [80];
    int got_cnt;
    int stall_bad;
    int bubbles;
    int sready_bad;
    int timed_out;
    int done_early;
    int sready_wrong;

    matvec_stream_feeder #(.K(8), .IW(14), .OW(28)) dut (
        .clk              (clk),
        .reset            (reset),
        .cfg_we           (cfg_we),
        .cfg_sel          (cfg_sel),
        .cfg_addr         (cfg_addr),
        .cfg_data         (cfg_data),
        .start            (start),
        .start_new_matrix (start_new_matrix),
        .hold_ready       (hold_ready),
        .busy             (busy),
        .done             (done),
        .m_valid          (m_valid),
        .m_ready          (m_ready),
        .m_data           (m_data),
        .m_new_matrix     (m_new_matrix),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .s_data           (s_data),
        .res_addr         (res_addr),
        .res_data         (res_data)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic cfg_write(input logic sel, input int addr, input int data);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_sel  = sel;
        cfg_addr = 6'(addr);
        cfg_data = 14'(data);
    endtask

    task automatic load_buffers();
        for (int i = 0; i < 64; i++) cfg_write(1'b0, i, tb_w[i]);
        for (int i = 0; i < 8; i++) cfg_write(1'b1, i, tb_x[i]);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Reference multiplier: y = W * X.
    task automatic compute_expected();
        for (int r = 0; r < 8; r++) begin
            exp_res[r] = 0;
            for (int c = 0; c < 8; c++) exp_res[r] += tb_w[r*8+c] * tb_x[c];
        end
    endtask

    task automatic do_start(input logic nm);
        @(negedge clk);
        start            = 1'b1;
        start_new_matrix = nm;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Acts as the multiplier input side; records each transferred word.
    task automatic drive_stream(input int mode, input int expect_words, input int budget);
        int prev_stall;
        int prev_data;
        int prev_nm;
        got_cnt = 0; stall_bad = 0; bubbles = 0; sready_bad = 0; timed_out = 0;
        prev_stall = 0; prev_data = 0; prev_nm = 0;
        for (int cyc = 0; cyc < budget && got_cnt < expect_words; cyc++) begin
            if (s_ready !== 1'b0) sready_bad++;
            if (prev_stall != 0) begin
                if (m_valid !== 1'b1 || int'(m_data) != prev_data || int'(m_new_matrix) != prev_nm)
                    stall_bad++;
            end
            if (m_valid !== 1'b1) bubbles++;
            m_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                got_data[got_cnt] = int'(m_data);
                got_nm[got_cnt]   = m_new_matrix ? 1 : 0;
                got_cnt++;
                prev_stall = 0;
            end else begin
                prev_stall = (m_valid === 1'b1) ? 1 : 0;
                prev_data  = int'(m_data);
                prev_nm    = int'(m_new_matrix);
            end
            @(negedge clk);
        end
        m_ready = 1'b0;
        if (got_cnt < expect_words) timed_out = 1;
    endtask

    // Acts as the multiplier output side; presents res_vals in order.
    task automatic drive_results(input int mode, input int budget);
        int sent;
        sent = 0; done_early = 0; timed_out = 0; sready_wrong = 0;
        for (int cyc = 0; cyc < budget && sent < 8; cyc++) begin
            if (done !== 1'b0) done_early++;
            s_valid    = 1'b1;
            s_data     = 28'(res_vals[sent]);
            hold_ready = (mode == 1 && (cyc % 2) == 1) ? 1'b1 : 1'b0;
            #1;
            if (s_ready !== !hold_ready) sready_wrong++;
            if (s_ready === 1'b1) sent++;
            @(negedge clk);
        end
        s_valid    = 1'b0;
        hold_ready = 1'b0;
        if (sent < 8) timed_out = 1;
    endtask

    task automatic test_reset();
        reset = 1'b1; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_data = '0;
        start = 1'b0; start_new_matrix = 1'b0; hold_ready = 1'b0; m_ready = 1'b0;
        s_valid = 1'b0; s_data = '0; res_addr = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_m_valid: got %b, expected 0", m_valid); end
        n_cmp++; if (m_new_matrix !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_m_new_matrix: got %b, expected 0", m_new_matrix); end
        n_cmp++; if (s_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_s_ready: got %b, expected 0", s_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_busy: got %b, expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_done: got %b, expected 0", done); end
        for (int i = 0; i < 8; i++) begin
            res_addr = 3'(i); #1;
            n_cmp++; if (res_data !== 28'sd0) begin n_fail++; $display("[TB] FAIL rst_res[%0d]: got %0d, expected 0", i, res_data); end
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_full_matrix();
        int errs;
        int nm_errs;
        for (int i = 0; i < 64; i++) tb_w[i] = ((i / 8) == (i % 8)) ? 2 : 0;
        for (int i = 0; i < 8; i++) tb_x[i] = i + 1;
        load_buffers();
        compute_expected();
        res_vals = exp_res;
        do_start(1'b1);
        drive_stream(0, 72, 400);
        n_cmp++; if (timed_out != 0) begin n_fail++; $display("[TB] FAIL full_send_timeout: got %0d words, expected 72", got_cnt); end
        n_cmp++; if (bubbles != 0) begin n_fail++; $display("[TB] FAIL full_bubbles: got %0d, expected 0", bubbles); end
        n_cmp++; if (sready_bad != 0) begin n_fail++; $display("[TB] FAIL full_s_ready_during_send: got %0d cycles high, expected 0", sready_bad); end
        errs = 0; nm_errs = 0;
        for (int i = 0; i < 72; i++) begin
            if (got_data[i] != ((i < 64) ? tb_w[i] : tb_x[i-64])) errs++;
            if (got_nm[i] != ((i == 0) ? 1 : 0)) nm_errs++;
        end
        n_cmp++; if (errs != 0) begin n_fail++; $display("[TB] FAIL full_order: got %0d wrong words, expected 0", errs); end
        n_cmp++; if (nm_errs != 0) begin n_fail++; $display("[TB] FAIL full_new_matrix: got %0d wrong flags, expected 0", nm_errs); end
        drive_results(0, 100);
        n_cmp++; if (timed_out != 0) begin n_fail++; $display("[TB] FAIL full_recv_timeout: got timeout, expected 8 captures"); end
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("[TB] FAIL full_done_pulse: got %b, expected 1", done); end
        n_cmp++; if (done_early != 0) begin n_fail++; $display("[TB] FAIL full_done_early: got %0d, expected 0", done_early); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL full_busy_in_fin: got %b, expected 1", busy); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL full_done_width: got %b, expected 0", done); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL full_busy_fall: got %b, expected 0", busy); end
        for (int i = 0; i < 8; i++) begin
            res_addr = 3'(i); #1;
            n_cmp++; if (int'(res_data) != 2 * (i + 1)) begin n_fail++; $display("[TB] FAIL full_res[%0d]: got %0d, expected %0d", i, res_data, 2 * (i + 1)); end
        end
    endtask

    task automatic test_vector_only();
        int errs;
        int nm_errs;
        for (int i = 0; i < 8; i++) tb_x[i] = 3 * i - 10;
        for (int i = 0; i < 8; i++) cfg_write(1'b1, i, tb_x[i]);
        @(negedge clk);
        cfg_we = 1'b0;
        compute_expected();
        res_vals = exp_res;
        s_valid = 1'b1;
        s_data  = 28'sd12345;
        do_start(1'b0);
        drive_stream(0, 8, 100);
        n_cmp++; if (timed_out != 0) begin n_fail++; $display("[TB] FAIL xonly_send_timeout: got %0d words, expected 8", got_cnt); end
        n_cmp++; if (sready_bad != 0) begin n_fail++; $display("[TB] FAIL xonly_s_ready_during_send: got %0d cycles high, expected 0", sready_bad); end
        errs = 0; nm_errs = 0;
        for (int i = 0; i < 8; i++) begin
            if (got_data[i] != tb_x[i]) errs++;
            if (got_nm[i] != 0) nm_errs++;
        end
        n_cmp++; if (errs != 0) begin n_fail++; $display("[TB] FAIL xonly_order: got %0d wrong words, expected 0", errs); end
        n_cmp++; if (nm_errs != 0) begin n_fail++; $display("[TB] FAIL xonly_new_matrix: got %0d flags high, expected 0", nm_errs); end
        n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL xonly_extra_word: got m_valid %b, expected 0", m_valid); end
        drive_results(0, 100);
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("[TB] FAIL xonly_done: got %b, expected 1", done); end
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            res_addr = 3'(i); #1;
            n_cmp++; if (int'(res_data) != 2 * (3 * i - 10)) begin n_fail++; $display("[TB] FAIL xonly_res[%0d]: got %0d, expected %0d", i, res_data, 2 * (3 * i - 10)); end
        end
    endtask

    task automatic test_random_ready();
        int errs;
        do_start(1'b1);
        drive_stream(1, 72, 2000);
        n_cmp++; if (timed_out != 0) begin n_fail++; $display("[TB] FAIL rand_send_timeout: got %0d words, expected 72", got_cnt); end
        n_cmp++; if (stall_bad != 0) begin n_fail++; $display("[TB] FAIL rand_stall_stable: got %0d unstable stalls, expected 0", stall_bad); end
        errs = 0;
        for (int i = 0; i < 72; i++) if (got_data[i] != ((i < 64) ? tb_w[i] : tb_x[i-64])) errs++;
        n_cmp++; if (errs != 0) begin n_fail++; $display("[TB] FAIL rand_order: got %0d wrong words, expected 0", errs); end
        n_cmp++; if (got_nm[0] != 1) begin n_fail++; $display("[TB] FAIL rand_new_matrix_first: got %0d, expected 1", got_nm[0]); end
        res_vals = exp_res;
        drive_results(0, 100);
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("[TB] FAIL rand_done: got %b, expected 1", done); end
        @(negedge clk);
    endtask

    task automatic test_hold_ready();
        do_start(1'b0);
        drive_stream(0, 8, 100);
        // start while busy must be ignored
        start = 1'b1; start_new_matrix = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL busy_start_ignored: got m_valid %b, expected 0", m_valid); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL busy_start_busy: got %b, expected 1", busy); end
        for (int i = 0; i < 8; i++) res_vals[i] = i - 5;
        drive_results(1, 100);
        n_cmp++; if (sready_wrong != 0) begin n_fail++; $display("[TB] FAIL hold_s_ready: got %0d wrong cycles, expected 0", sready_wrong); end
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("[TB] FAIL hold_done: got %b, expected 1", done); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL hold_idle: got busy %b, expected 0", busy); end
        for (int i = 0; i < 8; i++) begin
            res_addr = 3'(i); #1;
            n_cmp++; if (int'(res_data) != i - 5) begin n_fail++; $display("[TB] FAIL hold_res[%0d]: got %0d, expected %0d", i, res_data, i - 5); end
        end
    endtask

    task automatic test_reset_mid();
        int errs;
        do_start(1'b1);
        drive_stream(0, 30, 200);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_m_valid: got %b, expected 0", m_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_busy: got %b, expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_done: got %b, expected 0", done); end
        for (int i = 0; i < 8; i++) begin
            res_addr = 3'(i); #1;
            n_cmp++; if (res_data !== 28'sd0) begin n_fail++; $display("[TB] FAIL abort_res[%0d]: got %0d, expected 0", i, res_data); end
        end
        @(negedge clk);
        reset = 1'b0;
        do_start(1'b1);
        drive_stream(0, 72, 400);
        n_cmp++; if (got_data[0] != tb_w[0] || got_nm[0] != 1) begin n_fail++; $display("[TB] FAIL abort_replay_first: got %0d/%0d, expected %0d/1", got_data[0], got_nm[0], tb_w[0]); end
        errs = 0;
        for (int i = 0; i < 72; i++) if (got_data[i] != ((i < 64) ? tb_w[i] : tb_x[i-64])) errs++;
        n_cmp++; if (errs != 0) begin n_fail++; $display("[TB] FAIL abort_replay_order: got %0d wrong words, expected 0", errs); end
        res_vals = exp_res;
        drive_results(0, 100);
        @(negedge clk);
    endtask

    task automatic test_cfg_same_cycle();
        int errs;
        @(negedge clk);
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 6'd0; cfg_data = -14'sd8192;
        start = 1'b1; start_new_matrix = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0; start = 1'b0;
        tb_w[0] = -8192;
        n_cmp++; if (int'(m_data) != -8192) begin n_fail++; $display("[TB] FAIL cfg_same_cycle_first: got %0d, expected -8192", m_data); end
        drive_stream(0, 64, 300);
        // now presenting X[0]; writes here must be dropped
        cfg_we = 1'b1; cfg_sel = 1'b1; cfg_addr = 6'd0; cfg_data = 14'sd777;
        @(negedge clk);
        cfg_sel = 1'b0; cfg_addr = 6'd9; cfg_data = 14'sd555;
        @(negedge clk);
        cfg_we = 1'b0;
        drive_stream(0, 8, 100);
        errs = 0;
        for (int i = 0; i < 8; i++) if (got_data[i] != tb_x[i]) errs++;
        n_cmp++; if (errs != 0) begin n_fail++; $display("[TB] FAIL cfg_busy_x_stream: got %0d wrong words, expected 0", errs); end
        compute_expected();
        res_vals = exp_res;
        drive_results(0, 100);
        @(negedge clk);
        res_addr = 3'd0; #1;
        n_cmp++; if (int'(res_data) != 81920) begin n_fail++; $display("[TB] FAIL cfg_res0: got %0d, expected 81920", res_data); end
    endtask

    task automatic test_back_to_back();
        int errs;
        do_start(1'b0);
        drive_stream(0, 8, 100);
        for (int i = 0; i < 8; i++) res_vals[i] = -exp_res[i];
        drive_results(0, 100);
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_first_done: got %b, expected 1", done); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_idle_gap: got busy %b, expected 0", busy); end
        start = 1'b1; start_new_matrix = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++; if (m_valid !== 1'b1 || m_new_matrix !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_start: got valid %b nm %b, expected 1 1", m_valid, m_new_matrix); end
        drive_stream(0, 72, 400);
        errs = 0;
        for (int i = 0; i < 72; i++) if (got_data[i] != ((i < 64) ? tb_w[i] : tb_x[i-64])) errs++;
        n_cmp++; if (errs != 0) begin n_fail++; $display("[TB] FAIL b2b_readback_order: got %0d wrong words, expected 0", errs); end
        res_vals = exp_res;
        drive_results(0, 100);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            res_addr = 3'(i); #1;
            n_cmp++; if (int'(res_data) != exp_res[i]) begin n_fail++; $display("[TB] FAIL b2b_res[%0d]: got %0d, expected %0d", i, res_data, exp_res[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_full_matrix();
        test_vector_only();
        test_random_ready();
        test_hold_ready();
        test_reset_mid();
        test_cfg_same_cycle();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
